// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: drains `len` column vectors from the MAC output FIFO
// into consecutive psum SRAM addresses starting at `base_addr`.
// Optional feature macro: OFIFO_DRAIN_RELU_EN (clamp negative lanes to zero
// in the capture register).
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int rd_lat  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        len,
    input  logic [addr_w-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_w-1:0]        sram_addr,
    output logic [col*psum_bw-1:0]   sram_d
);

    localparam int DW = col * psum_bw;
    localparam int LW = (rd_lat > 1) ? $clog2(rd_lat) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(rd_lat - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [addr_w-1:0] len_q;
    logic [addr_w-1:0] base_q;
    logic [addr_w-1:0] cnt;
    logic [LW-1:0]     lat_cnt;
    logic [DW-1:0]     capture_data;

    // Data presented to the capture register (optionally ReLU-clamped per lane)
    always_comb begin
        capture_data = ofifo_out;
`ifdef OFIFO_DRAIN_RELU_EN
        for (int unsigned i = 0; i < col; i++) begin
            if (ofifo_out[i*psum_bw + psum_bw - 1]) begin
                capture_data[i*psum_bw +: psum_bw] = '0;
            end
        end
`endif
    end

    // Drain sequencer; every output is a flop. Actions decided in a state are
    // visible on the outputs in the following cycle, and busy stays high
    // through the done cycle so start is ignored until the first quiet IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            len_q     <= '0;
            base_q    <= '0;
            cnt       <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ofifo_rd  <= 1'b0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
        end else begin
            ofifo_rd <= 1'b0;
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            done     <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start && !busy) begin
                        len_q  <= len;
                        base_q <= base_addr;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= (len == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ofifo_valid) begin
                        ofifo_rd <= 1'b1;
                        lat_cnt  <= LAT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        sram_d <= capture_data;
                        state  <= S_WRITE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    sram_cen  <= 1'b0;
                    sram_wen  <= 1'b0;
                    sram_addr <= base_q + cnt;
                    cnt       <= cnt + 1'b1;
                    state     <= (cnt + 1'b1 == len_q) ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Directed bench for ofifo_drain_ctrl with a simple FIFO model (rd_lat = 2).
module tb_ofifo_drain_ctrl;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int AW  = 11;
    localparam int RDL = 2;
    localparam int DW  = COL * PBW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] len;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          ofifo_valid;
    logic          ofifo_rd;
    logic [DW-1:0] ofifo_out = '0;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_d;

    ofifo_drain_ctrl #(.col(COL), .psum_bw(PBW), .addr_w(AW), .rd_lat(RDL)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
        .busy(busy), .done(done), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .ofifo_out(ofifo_out), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_d(sram_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears one edge after the read strobe is sampled,
    // so the DUT sees it at the rd_lat-th edge after raising ofifo_rd.
    logic [DW-1:0] mem [64];
    int wptr = 0;
    int rptr = 0;
    int overrd = 0;
    int lo = -1;
    int hi = -1;
    assign ofifo_valid = (wptr != rptr) && !(cyc >= lo && cyc <= hi);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr <= wptr;
        end else if (ofifo_rd) begin
            if (rptr == wptr) begin
                overrd <= overrd + 1;
            end else begin
                ofifo_out <= mem[rptr % 64];
                rptr      <= rptr + 1;
            end
        end
    end

    // Activity log
    int            rd_n = 0, wr_n = 0, done_n = 0;
    int            rd_cyc [64];
    int            wr_cyc [64];
    int            done_cyc [64];
    logic [AW-1:0] wa [64];
    logic [DW-1:0] wd [64];
    int            busy_fall = -1;
    logic          busy_d = 1'b0;

    always @(negedge clk) begin
        if (ofifo_rd) begin
            rd_cyc[rd_n % 64] = cyc;
            rd_n++;
        end
        if (!sram_cen && !sram_wen) begin
            wr_cyc[wr_n % 64] = cyc;
            wa[wr_n % 64] = sram_addr;
            wd[wr_n % 64] = sram_d;
            wr_n++;
        end
        if (done) begin
            done_cyc[done_n % 64] = cyc;
            done_n++;
        end
        if (busy_d && !busy) busy_fall = cyc;
        busy_d = busy;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wptr % 64] = v;
        wptr++;
    endtask

    task automatic start_job(input logic [AW-1:0] l, input logic [AW-1:0] b, output int s);
        @(negedge clk);
        #1;
        len = l;
        base_addr = b;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_n == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", (done_n > d0), 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    int s, r0, w0, d0;
    logic [DW-1:0] relu_in, relu_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", ofifo_rd, 0);
        check("rst_cen", sram_cen, 1);
        check("rst_wen", sram_wen, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_d", sram_d, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic drain
        for (int i = 1; i <= 4; i++) push(DW'(i));
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd4, 11'd10, s);
        check("busy_after_start", busy, 1);
        wait_done(d0, 100);
        check("basic_rd_n", rd_n - r0, 4);
        check("basic_wr_n", wr_n - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_addr%0d", i), wa[w0 + i], 10 + i);
            check($sformatf("basic_data%0d", i), wd[w0 + i], i + 1);
        end
        check("basic_first_rd", rd_cyc[r0] - s, 2);
        check("basic_rd_spacing", rd_cyc[r0 + 1] - rd_cyc[r0], 4);
        check("basic_rd_span", rd_cyc[r0 + 3] - rd_cyc[r0], 12);
        check("basic_wr_lat", wr_cyc[w0] - rd_cyc[r0], 3);
        check("basic_done_lat", done_cyc[d0] - rd_cyc[r0 + 3], 4);
        check("basic_done_n", done_n - d0, 1);
        check("basic_busy_fall", busy_fall - done_cyc[d0], 1);

        // Stall: valid low across the second ISSUE
        for (int i = 0; i < 3; i++) push(DW'(32'h100 + i));
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd3, 11'd50, s);
        lo = s + 3; hi = s + 9;
        wait_done(d0, 100);
        lo = -1; hi = -1;
        check("stall_rd_n", rd_n - r0, 3);
        check("stall_wr_n", wr_n - w0, 3);
        check("stall_gap", rd_cyc[r0 + 1] - rd_cyc[r0], 9);
        check("stall_resume", rd_cyc[r0 + 2] - rd_cyc[r0 + 1], 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_addr%0d", i), wa[w0 + i], 50 + i);
            check($sformatf("stall_data%0d", i), wd[w0 + i], 32'h100 + i);
        end

        // Address wrap
        for (int i = 0; i < 3; i++) push(DW'(32'h20 + i));
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd3, 11'd2046, s);
        wait_done(d0, 100);
        check("wrap_wr_n", wr_n - w0, 3);
        check("wrap_addr0", wa[w0], 2046);
        check("wrap_addr1", wa[w0 + 1], 2047);
        check("wrap_addr2", wa[w0 + 2], 0);

        // Zero length
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd0, 11'd7, s);
        wait_done(d0, 20);
        check("len0_done_lat", done_cyc[d0] - s, 2);
        check("len0_rd_n", rd_n - r0, 0);
        check("len0_wr_n", wr_n - w0, 0);

        // Reset during WAIT of vector 2 of 5
        for (int i = 0; i < 5; i++) push(DW'(32'hA0 + i));
        start_job(11'd5, 11'd300, s);
        repeat (5) @(negedge clk);
        #1;
        check("mid_rd_before_reset", ofifo_rd, 1);
        check("mid_addr_before_reset", sram_addr, 300);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd", ofifo_rd, 0);
        check("mid_rst_cen", sram_cen, 1);
        check("mid_rst_wen", sram_wen, 1);
        check("mid_rst_addr", sram_addr, 0);
        check("mid_rst_d", sram_d, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        push(DW'(32'h77));
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd1, 11'd5, s);
        wait_done(d0, 50);
        check("post_rst_rd_n", rd_n - r0, 1);
        check("post_rst_wr_n", wr_n - w0, 1);
        check("post_rst_addr", wa[w0], 5);
        check("post_rst_data", wd[w0], 32'h77);

        // Start while busy is ignored
        for (int i = 0; i < 3; i++) push(DW'(32'h300 + i));
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        start_job(11'd3, 11'd20, s);
        repeat (2) @(negedge clk);
        #1;
        len = 11'd7; base_addr = 11'd100; start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, 100);
        repeat (20) @(negedge clk);
        #1;
        check("busy_start_wr_n", wr_n - w0, 3);
        check("busy_start_rd_n", rd_n - r0, 3);
        check("busy_start_addr0", wa[w0], 20);
        check("busy_start_addr2", wa[w0 + 2], 22);
        check("busy_start_done_n", done_n - d0, 1);
        check("busy_start_idle", busy, 0);

        // Lane clamp
        relu_in = {16'h1234, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFF0};
`ifdef OFIFO_DRAIN_RELU_EN
        relu_exp = {16'h1234, 16'h0000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 16'h0005, 16'h0000};
`else
        relu_exp = {16'h1234, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFF0};
`endif
        push(relu_in);
        w0 = wr_n; d0 = done_n;
        start_job(11'd1, 11'd400, s);
        wait_done(d0, 50);
        check("relu_wr_n", wr_n - w0, 1);
        check("relu_data", wd[w0], relu_exp);

        check("no_overread", overrd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
